// File: rtl/orbit_pkg.sv
// ----------------------------------------------------------------------------
// orbit_pkg
//   Shared types and constants for the orbit game sequencer.
//   - game_state_t : sequencer state, encoding visible on the game_state output
//   - COL_*        : colour codes driven to the colour mapper
//   - QSIN         : quarter-wave sine table, QSIN[k] = round(256*sin(k*5.625 deg))
//   - BALL_SIZE    : constant ball size reported to the renderer
// ----------------------------------------------------------------------------
package orbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    localparam logic [1:0] COL_BLUE = 2'b00;
    localparam logic [1:0] COL_RED  = 2'b01;
    localparam logic [1:0] COL_DEAD = 2'b10;

    localparam logic [9:0] BALL_SIZE = 10'd4;

    // 9 bits so that the full-scale entry (256) is representable.
    localparam logic [8:0] QSIN [0:16] = '{
        9'd0,   9'd25,  9'd50,  9'd74,  9'd98,  9'd121, 9'd142, 9'd162, 9'd181,
        9'd198, 9'd213, 9'd226, 9'd237, 9'd245, 9'd251, 9'd255, 9'd256
    };

endpackage

// File: rtl/orbit_controller_if.sv
// ----------------------------------------------------------------------------
// orbit_controller_if
//   Bundles the keyboard/collision inputs and the ball/game outputs of the
//   orbit sequencer.
//   master : keyboard + collision side (drives keycode, hit_red, hit_blue)
//   slave  : orbit_controller (drives ball centres, colours, lives, state, phase)
// ----------------------------------------------------------------------------
interface orbit_controller_if;
    import orbit_pkg::*;

    logic [7:0]  keycode;
    logic        hit_red;
    logic        hit_blue;
    logic [9:0]  RedX;
    logic [9:0]  RedY;
    logic [9:0]  BlueX;
    logic [9:0]  BlueY;
    logic [9:0]  BallS;
    logic [1:0]  RedColor;
    logic [1:0]  BlueColor;
    logic [1:0]  lives;
    game_state_t game_state;
    logic [5:0]  phase;

    modport master (
        output keycode, hit_red, hit_blue,
        input  RedX, RedY, BlueX, BlueY, BallS,
        input  RedColor, BlueColor, lives, game_state, phase
    );

    modport slave (
        input  keycode, hit_red, hit_blue,
        output RedX, RedY, BlueX, BlueY, BallS,
        output RedColor, BlueColor, lives, game_state, phase
    );
endinterface

// File: rtl/orbit_trig_lut.sv
// ----------------------------------------------------------------------------
// orbit_trig_lut
//   Combinational phase -> (dx, dy) offset for a point on a circle of radius
//   RADIUS. 64 phase steps per revolution; dx = R*cos, dy = R*sin, using
//   quadrant symmetry over the quarter-wave table QSIN.
//   Ports:
//     i_phase  in   6   orbit phase
//     o_dx     out  10  signed X offset (two's complement)
//     o_dy     out  10  signed Y offset (two's complement)
// ----------------------------------------------------------------------------
module orbit_trig_lut
    import orbit_pkg::*;
#(
    parameter int RADIUS = 60
) (
    input  logic        [5:0] i_phase,
    output logic signed [9:0] o_dx,
    output logic signed [9:0] o_dy
);

    logic [1:0]  w_quad;
    logic [4:0]  w_k;
    logic [4:0]  w_idx_sin;
    logic [4:0]  w_idx_cos;
    logic        w_neg_sin;
    logic        w_neg_cos;
    logic [15:0] w_prod_sin;
    logic [15:0] w_prod_cos;
    logic [9:0]  w_mag_sin;
    logic [9:0]  w_mag_cos;

    always_comb begin
        w_quad = i_phase[5:4];
        w_k    = {1'b0, i_phase[3:0]};

        // Odd quadrants run the table backwards; sin/cos swap roles there.
        w_idx_sin = w_quad[0] ? (5'd16 - w_k) : w_k;
        w_idx_cos = w_quad[0] ? w_k : (5'd16 - w_k);

        // sin is negative in quadrants 2,3; cos in quadrants 1,2.
        w_neg_sin = w_quad[1];
        w_neg_cos = w_quad[1] ^ w_quad[0];

        // RADIUS <= 127 and QSIN <= 256 keep the product inside 16 bits.
        w_prod_sin = 16'(RADIUS) * {7'd0, QSIN[w_idx_sin]};
        w_prod_cos = 16'(RADIUS) * {7'd0, QSIN[w_idx_cos]};

        w_mag_sin = {2'b00, w_prod_sin[15:8]};
        w_mag_cos = {2'b00, w_prod_cos[15:8]};

        o_dy = w_neg_sin ? -$signed(w_mag_sin) : $signed(w_mag_sin);
        o_dx = w_neg_cos ? -$signed(w_mag_cos) : $signed(w_mag_cos);
    end

endmodule

// File: rtl/orbit_controller.sv
// ----------------------------------------------------------------------------
// orbit_controller
//   Per-frame game sequencer for the red/blue balls orbiting a common centre.
//   Decodes the keycode into rotation, keeps the 6-bit orbit phase, produces
//   both ball centres (blue is half a turn ahead of red), colours, lives and
//   the game state.
//   Ports:
//     Reset      in   1   asynchronous, active-high reset
//     frame_clk  in   1   one rising edge per video frame
//     bus        slave modport of orbit_controller_if
//                  keycode/hit_red/hit_blue in; RedX/RedY/BlueX/BlueY/BallS,
//                  RedColor/BlueColor, lives, game_state, phase out
// ----------------------------------------------------------------------------
module orbit_controller
    import orbit_pkg::*;
#(
    parameter int         CENTER_X   = 320,
    parameter int         CENTER_Y   = 360,
    parameter int         RADIUS     = 60,
    parameter int         STEP       = 1,
    parameter int         HIT_FRAMES = 60,
    parameter int         LIVES      = 3,
    parameter logic [7:0] KEY_CW     = 8'h07,
    parameter logic [7:0] KEY_CCW    = 8'h04,
    parameter logic [7:0] KEY_START  = 8'h2C
) (
    input  logic               Reset,
    input  logic               frame_clk,
    orbit_controller_if.slave  bus
);

    localparam int CNT_W = $clog2(HIT_FRAMES + 1);

    game_state_t       r_state;
    logic [5:0]        r_phase;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [1:0]        r_lives;
    logic [1:0]        r_red_color;
    logic [1:0]        r_blue_color;
    logic [9:0]        r_red_x;
    logic [9:0]        r_red_y;
    logic [9:0]        r_blue_x;
    logic [9:0]        r_blue_y;

    logic              w_any_hit;
    logic              w_hit_expire;
    logic [5:0]        w_phase_next;
    logic [5:0]        w_lut_phase [2];
    logic signed [9:0] w_dx [2];
    logic signed [9:0] w_dy [2];

    assign w_any_hit    = bus.hit_red | bus.hit_blue;
    assign w_hit_expire = (r_hit_cnt == CNT_W'(HIT_FRAMES - 1));

    // Next phase is computed combinationally so the ball centres can be
    // registered from it and move on the same edge as the phase output.
    always_comb begin
        w_phase_next = r_phase;
        case (r_state)
            ST_IDLE: w_phase_next = 6'd0;
            ST_PLAY: begin
                // A hit freezes the phase on the hit edge, rotation key or not.
                if (!w_any_hit) begin
                    if (bus.keycode == KEY_CW)
                        w_phase_next = r_phase + 6'(STEP);
                    else if (bus.keycode == KEY_CCW)
                        w_phase_next = r_phase - 6'(STEP);
                end
            end
            ST_HIT:  if (w_hit_expire) w_phase_next = 6'd0;
            ST_OVER: w_phase_next = 6'd0;
        endcase
    end

    // Index 0 = red ball, index 1 = blue ball (half a revolution ahead).
    assign w_lut_phase[0] = w_phase_next;
    assign w_lut_phase[1] = w_phase_next + 6'd32;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ball
        orbit_trig_lut #(
            .RADIUS (RADIUS)
        ) u_lut (
            .i_phase (w_lut_phase[gi]),
            .o_dx    (w_dx[gi]),
            .o_dy    (w_dy[gi])
        );
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_phase      <= 6'd0;
            r_hit_cnt    <= '0;
            r_lives      <= 2'(LIVES);
            r_red_color  <= COL_RED;
            r_blue_color <= COL_BLUE;
            r_red_x      <= 10'(CENTER_X + RADIUS);
            r_red_y      <= 10'(CENTER_Y);
            r_blue_x     <= 10'(CENTER_X - RADIUS);
            r_blue_y     <= 10'(CENTER_Y);
        end else begin
            r_phase  <= w_phase_next;
            r_red_x  <= 10'(CENTER_X) + $unsigned(w_dx[0]);
            r_red_y  <= 10'(CENTER_Y) + $unsigned(w_dy[0]);
            r_blue_x <= 10'(CENTER_X) + $unsigned(w_dx[1]);
            r_blue_y <= 10'(CENTER_Y) + $unsigned(w_dy[1]);

            case (r_state)
                ST_IDLE: begin
                    if (bus.keycode == KEY_START)
                        r_state <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (w_any_hit) begin
                        r_state   <= ST_HIT;
                        r_hit_cnt <= '0;
                        // One life per hit event, even if both balls are hit.
                        r_lives   <= r_lives - 2'd1;
                        if (bus.hit_red)  r_red_color  <= COL_DEAD;
                        if (bus.hit_blue) r_blue_color <= COL_DEAD;
                    end
                end
                ST_HIT: begin
                    if (w_hit_expire) begin
                        r_state      <= (r_lives == 2'd0) ? ST_OVER : ST_IDLE;
                        r_hit_cnt    <= '0;
                        r_red_color  <= COL_RED;
                        r_blue_color <= COL_BLUE;
                    end else begin
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                    end
                end
                ST_OVER: begin
                    r_red_color  <= COL_RED;
                    r_blue_color <= COL_BLUE;
                    if (bus.keycode == KEY_START) begin
                        r_state <= ST_IDLE;
                        r_lives <= 2'(LIVES);
                    end
                end
            endcase
        end
    end

    assign bus.RedX       = r_red_x;
    assign bus.RedY       = r_red_y;
    assign bus.BlueX      = r_blue_x;
    assign bus.BlueY      = r_blue_y;
    assign bus.BallS      = BALL_SIZE;
    assign bus.RedColor   = r_red_color;
    assign bus.BlueColor  = r_blue_color;
    assign bus.lives      = r_lives;
    assign bus.game_state = r_state;
    assign bus.phase      = r_phase;

endmodule

// File: tb/tb_orbit_controller.sv
// ----------------------------------------------------------------------------
// tb_orbit_controller
//   Self-checking bench for orbit_controller: a directed vector table, hand
//   sequences for the HIT/OVER/reset corners, then randomized frames checked
//   against a behavioural model that derives ball positions from real-valued
//   trigonometry.
// ----------------------------------------------------------------------------
module tb_orbit_controller;

    localparam int         CX      = 320;
    localparam int         CY      = 360;
    localparam int         RAD     = 60;
    localparam int         STP     = 1;
    localparam int         HFR     = 60;
    localparam int         NLIVES  = 3;
    localparam logic [7:0] K_CW    = 8'h07;
    localparam logic [7:0] K_CCW   = 8'h04;
    localparam logic [7:0] K_START = 8'h2C;
    localparam real        PI      = 3.14159265358979;

    logic Reset;
    logic frame_clk;

    orbit_controller_if bus ();

    orbit_controller #(
        .CENTER_X   (CX),
        .CENTER_Y   (CY),
        .RADIUS     (RAD),
        .STEP       (STP),
        .HIT_FRAMES (HFR),
        .LIVES      (NLIVES),
        .KEY_CW     (K_CW),
        .KEY_CCW    (K_CCW),
        .KEY_START  (K_START)
    ) dut (
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_frame = 0;

    // ---------------- behavioural model ----------------
    int m_state, m_phase, m_lives, m_left;
    bit m_red_dead, m_blue_dead;

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_lives = NLIVES; m_left = 0;
        m_red_dead = 1'b0; m_blue_dead = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] k, input logic hr, input logic hb);
        case (m_state)
            0: begin
                m_phase = 0;
                if (k == K_START) m_state = 1;
            end
            1: begin
                if (hr || hb) begin
                    m_state = 2; m_lives = m_lives - 1; m_left = HFR;
                    m_red_dead = hr; m_blue_dead = hb;
                end else if (k == K_CW) begin
                    m_phase = (m_phase + STP) % 64;
                end else if (k == K_CCW) begin
                    m_phase = (m_phase - STP + 64) % 64;
                end
            end
            2: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_red_dead = 1'b0; m_blue_dead = 1'b0; m_phase = 0;
                    m_state = (m_lives == 0) ? 3 : 0;
                end
            end
            default: begin
                m_phase = 0;
                if (k == K_START) begin m_state = 0; m_lives = NLIVES; end
            end
        endcase
    endtask

    // Offset along one axis for phase ph, from real sin/cos.
    function automatic int off_trig(input int ph, input bit use_cos);
        real a, s, m;
        int  q;
        a = ph * 5.625 * PI / 180.0;
        s = use_cos ? $cos(a) : $sin(a);
        m = (s < 0.0) ? -s : s;
        q = $rtoi(256.0 * m + 0.5);
        q = (RAD * q) / 256;
        return (s < 0.0) ? -q : q;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (frame %0d)", name, act, exp, n_frame);
        end
    endtask

    task automatic check_model();
        int bp;
        bp = (m_phase + 32) % 64;
        chk("state",     int'(bus.game_state), m_state);
        chk("phase",     int'(bus.phase),      m_phase);
        chk("lives",     int'(bus.lives),      m_lives);
        chk("RedColor",  int'(bus.RedColor),   m_red_dead  ? 2 : 1);
        chk("BlueColor", int'(bus.BlueColor),  m_blue_dead ? 2 : 0);
        chk("RedX",      int'(bus.RedX),       CX + off_trig(m_phase, 1'b1));
        chk("RedY",      int'(bus.RedY),       CY + off_trig(m_phase, 1'b0));
        chk("BlueX",     int'(bus.BlueX),      CX + off_trig(bp, 1'b1));
        chk("BlueY",     int'(bus.BlueY),      CY + off_trig(bp, 1'b0));
        chk("BallS",     int'(bus.BallS),      4);
    endtask

    // Apply one frame's inputs, clock, then check outputs 1 time unit later.
    task automatic frame(input logic [7:0] k, input logic hr, input logic hb);
        bus.keycode = k; bus.hit_red = hr; bus.hit_blue = hb;
        @(posedge frame_clk);
        model_edge(k, hr, hb);
        #1;
        n_frame++;
        $display("frame %0d key=%02h hr=%0d hb=%0d -> state=%0d phase=%0d lives=%0d red=(%0d,%0d) blue=(%0d,%0d)",
                 n_frame, k, hr, hb, bus.game_state, bus.phase, bus.lives,
                 bus.RedX, bus.RedY, bus.BlueX, bus.BlueY);
        check_model();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, int'(bus.game_state), 0);
        chk({tag, "_phase"}, int'(bus.phase), 0);
        chk({tag, "_RedX"},  int'(bus.RedX), 380);
        chk({tag, "_RedY"},  int'(bus.RedY), 360);
        chk({tag, "_BlueX"}, int'(bus.BlueX), 260);
        chk({tag, "_BlueY"}, int'(bus.BlueY), 360);
        chk({tag, "_RedC"},  int'(bus.RedColor), 1);
        chk({tag, "_BlueC"}, int'(bus.BlueColor), 0);
        chk({tag, "_lives"}, int'(bus.lives), 3);
        chk({tag, "_BallS"}, int'(bus.BallS), 4);
    endtask

    // Short reset pulse placed between frame edges.
    task automatic do_reset();
        bus.keycode = 8'h00; bus.hit_red = 1'b0; bus.hit_blue = 1'b0;
        Reset = 1'b1;
        #3;
        Reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] key;
        logic       hr;
        logic       hb;
        int         st, ph, lv, rc, bc, rx, ry, bx, by;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic [7:0] k;
        logic hr, hb;

        tbl[0] = '{K_START, 1'b0, 1'b0, 1, 0,  3, 1, 0, 380, 360, 260, 360};
        tbl[1] = '{K_CW,    1'b0, 1'b0, 1, 1,  3, 1, 0, 379, 365, 261, 355};
        tbl[2] = '{K_CCW,   1'b0, 1'b0, 1, 0,  3, 1, 0, 380, 360, 260, 360};
        tbl[3] = '{K_CCW,   1'b0, 1'b0, 1, 63, 3, 1, 0, 379, 355, 261, 365};
        tbl[4] = '{K_CW,    1'b0, 1'b0, 1, 0,  3, 1, 0, 380, 360, 260, 360};
        tbl[5] = '{K_START, 1'b0, 1'b0, 1, 0,  3, 1, 0, 380, 360, 260, 360};
        tbl[6] = '{8'h16,   1'b0, 1'b0, 1, 0,  3, 1, 0, 380, 360, 260, 360};
        tbl[7] = '{K_CW,    1'b1, 1'b0, 2, 0,  2, 2, 0, 380, 360, 260, 360};

        // T1: reset values
        Reset = 1'b1;
        bus.keycode = 8'h00; bus.hit_red = 1'b0; bus.hit_blue = 1'b0;
        model_reset();
        #11;
        check_reset_vals("T1");
        #1;
        Reset = 1'b0;

        // Vector table: start, wrap both ways, ignored keys, hit freezes phase
        for (int i = 0; i < 8; i++) begin
            frame(tbl[i].key, tbl[i].hr, tbl[i].hb);
            chk($sformatf("tbl%0d_state", i), int'(bus.game_state), tbl[i].st);
            chk($sformatf("tbl%0d_phase", i), int'(bus.phase),      tbl[i].ph);
            chk($sformatf("tbl%0d_lives", i), int'(bus.lives),      tbl[i].lv);
            chk($sformatf("tbl%0d_redc", i),  int'(bus.RedColor),   tbl[i].rc);
            chk($sformatf("tbl%0d_bluec", i), int'(bus.BlueColor),  tbl[i].bc);
            chk($sformatf("tbl%0d_redx", i),  int'(bus.RedX),       tbl[i].rx);
            chk($sformatf("tbl%0d_redy", i),  int'(bus.RedY),       tbl[i].ry);
            chk($sformatf("tbl%0d_bluex", i), int'(bus.BlueX),      tbl[i].bx);
            chk($sformatf("tbl%0d_bluey", i), int'(bus.BlueY),      tbl[i].by);
        end

        // T2: a quarter turn clockwise
        do_reset();
        frame(K_START, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) frame(K_CW, 1'b0, 1'b0);
        chk("T2_state", int'(bus.game_state), 1);
        chk("T2_phase", int'(bus.phase), 16);
        chk("T2_RedX",  int'(bus.RedX), 320);
        chk("T2_RedY",  int'(bus.RedY), 420);
        chk("T2_BlueX", int'(bus.BlueX), 320);
        chk("T2_BlueY", int'(bus.BlueY), 300);

        // T4: blue hit with CW held; exactly 60 frames in HIT
        frame(K_CW, 1'b0, 1'b1);
        chk("T4_state", int'(bus.game_state), 2);
        chk("T4_bluec", int'(bus.BlueColor), 2);
        chk("T4_redc",  int'(bus.RedColor), 1);
        chk("T4_phase", int'(bus.phase), 16);
        chk("T4_lives", int'(bus.lives), 2);
        for (int i = 0; i < HFR - 1; i++) frame(K_CW, 1'b1, 1'b0);
        chk("T4_still_hit", int'(bus.game_state), 2);
        chk("T4_frozen_y",  int'(bus.RedY), 420);
        frame(8'h00, 1'b0, 1'b0);
        chk("T4_exit_state", int'(bus.game_state), 0);
        chk("T4_exit_phase", int'(bus.phase), 0);
        chk("T4_exit_bluec", int'(bus.BlueColor), 0);

        // T5: three hits (first one on both balls) to game over, then restart
        do_reset();
        frame(K_START, 1'b0, 1'b0);
        frame(8'h00, 1'b1, 1'b1);
        chk("T5_both_lives", int'(bus.lives), 2);
        chk("T5_both_redc",  int'(bus.RedColor), 2);
        chk("T5_both_bluec", int'(bus.BlueColor), 2);
        for (int i = 0; i < HFR; i++) frame(8'h00, 1'b0, 1'b0);
        frame(K_START, 1'b0, 1'b0);
        frame(K_CCW, 1'b1, 1'b0);
        chk("T5_hit2_lives", int'(bus.lives), 1);
        for (int i = 0; i < HFR; i++) frame(K_START, 1'b0, 1'b0);
        chk("T5_hit2_idle", int'(bus.game_state), 0);
        frame(K_START, 1'b0, 1'b0);
        frame(K_CW, 1'b0, 1'b1);
        chk("T5_hit3_lives", int'(bus.lives), 0);
        for (int i = 0; i < HFR; i++) frame(8'h00, 1'b0, 1'b0);
        chk("T5_over_state", int'(bus.game_state), 3);
        chk("T5_over_bluec", int'(bus.BlueColor), 0);
        frame(K_CW, 1'b0, 1'b0);
        chk("T5_over_hold", int'(bus.game_state), 3);
        frame(K_START, 1'b0, 1'b0);
        chk("T5_restart_state", int'(bus.game_state), 0);
        chk("T5_restart_lives", int'(bus.lives), 3);

        // T6: asynchronous reset in the middle of HIT
        frame(K_START, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) frame(K_CW, 1'b0, 1'b0);
        frame(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) frame(8'h00, 1'b0, 1'b0);
        bus.keycode = 8'h00;
        #3;
        Reset = 1'b1;
        #1;
        check_reset_vals("T6");
        #2;
        Reset = 1'b0;
        model_reset();

        // Randomized frames against the model
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       k = K_CW;
            else if (r < 7)  k = K_CCW;
            else if (r == 7) k = K_START;
            else if (r == 8) k = 8'h00;
            else             k = 8'($urandom_range(0, 255));
            hr = ($urandom_range(0, 99) < 3);
            hb = ($urandom_range(0, 99) < 3);
            frame(k, hr, hb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
